// File: rtl/axil_xvc_led_split.sv
// AXI4-Lite 1-to-2 router: forwards the XVC window to the debug bridge, serves a
// small local LED/scratch/counter/ID bank, and answers everything else with DECERR.
module axil_xvc_led_split #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    STRB_WIDTH = DATA_WIDTH/8,
    parameter logic [ADDR_WIDTH-1:0] XVC_BASE   = 16'h0000,
    parameter int                    XVC_AW     = 5,
    parameter logic [ADDR_WIDTH-1:0] LOC_BASE   = 16'h0100,
    parameter logic [7:0]            LED_RST    = 8'h00
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,
    output logic [XVC_AW-1:0]     m_axil_awaddr,
    output logic [2:0]            m_axil_awprot,
    output logic                  m_axil_awvalid,
    input  logic                  m_axil_awready,
    output logic [DATA_WIDTH-1:0] m_axil_wdata,
    output logic [STRB_WIDTH-1:0] m_axil_wstrb,
    output logic                  m_axil_wvalid,
    input  logic                  m_axil_wready,
    input  logic [1:0]            m_axil_bresp,
    input  logic                  m_axil_bvalid,
    output logic                  m_axil_bready,
    output logic [XVC_AW-1:0]     m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,
    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,
    output logic [7:0]            LED
);
    localparam logic [1:0]            RESP_OKAY   = 2'b00;
    localparam logic [1:0]            RESP_DECERR = 2'b11;
    localparam logic [DATA_WIDTH-1:0] ID_VAL      = 32'h5856_4331;

    typedef enum logic [1:0] {WIDLE, WFWD, WBWAIT, WRSP} wstate_t;
    typedef enum logic [1:0] {RIDLE, RFWD, RWAIT, RRSP} rstate_t;

    wstate_t r_wstate, w_wstate_nxt;
    rstate_t r_rstate, w_rstate_nxt;

    logic [7:0]            r_led;
    logic [DATA_WIDTH-1:0] r_scratch;
    logic [DATA_WIDTH-1:0] r_free_cnt;
    logic [1:0]            r_bresp;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_m_awvalid;
    logic                  r_m_wvalid;
    logic [XVC_AW-1:0]     r_m_awaddr;
    logic [2:0]            r_m_awprot;
    logic [DATA_WIDTH-1:0] r_m_wdata;
    logic [STRB_WIDTH-1:0] r_m_wstrb;
    logic [XVC_AW-1:0]     r_m_araddr;
    logic [2:0]            r_m_arprot;

    logic                  w_aw_hs, w_aw_fwd, w_aw_loc, w_loc_wr;
    logic                  w_ar_hs, w_ar_fwd, w_ar_loc;
    logic                  w_m_aw_done, w_m_w_done;
    logic [DATA_WIDTH-1:0] w_loc_rdata;

    // AW and W are accepted only together so a write is always a single event.
    assign w_aw_hs  = (r_wstate == WIDLE) & s_axil_awvalid & s_axil_wvalid;
    assign w_aw_fwd = s_axil_awaddr[ADDR_WIDTH-1:XVC_AW] == XVC_BASE[ADDR_WIDTH-1:XVC_AW];
    assign w_aw_loc = s_axil_awaddr[ADDR_WIDTH-1:4] == LOC_BASE[ADDR_WIDTH-1:4];
    assign w_loc_wr = w_aw_hs & ~w_aw_fwd & w_aw_loc;
    assign w_ar_hs  = (r_rstate == RIDLE) & s_axil_arvalid;
    assign w_ar_fwd = s_axil_araddr[ADDR_WIDTH-1:XVC_AW] == XVC_BASE[ADDR_WIDTH-1:XVC_AW];
    assign w_ar_loc = s_axil_araddr[ADDR_WIDTH-1:4] == LOC_BASE[ADDR_WIDTH-1:4];

    assign w_m_aw_done = ~r_m_awvalid | m_axil_awready;
    assign w_m_w_done  = ~r_m_wvalid | m_axil_wready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_wstate <= WIDLE;
            r_rstate <= RIDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            WIDLE:   if (w_aw_hs) w_wstate_nxt = w_aw_fwd ? WFWD : WRSP;
            WFWD:    if (w_m_aw_done && w_m_w_done) w_wstate_nxt = WBWAIT;
            WBWAIT:  if (m_axil_bvalid) w_wstate_nxt = WRSP;
            WRSP:    if (s_axil_bready) w_wstate_nxt = WIDLE;
            default: w_wstate_nxt = WIDLE;
        endcase
    end

    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            RIDLE:   if (w_ar_hs) w_rstate_nxt = w_ar_fwd ? RFWD : RRSP;
            RFWD:    if (m_axil_arready) w_rstate_nxt = RWAIT;
            RWAIT:   if (m_axil_rvalid) w_rstate_nxt = RRSP;
            RRSP:    if (s_axil_rready) w_rstate_nxt = RIDLE;
            default: w_rstate_nxt = RIDLE;
        endcase
    end

    always_comb begin
        s_axil_awready = w_aw_hs;
        s_axil_wready  = w_aw_hs;
        s_axil_bvalid  = (r_wstate == WRSP);
        s_axil_bresp   = r_bresp;
        m_axil_awvalid = r_m_awvalid;
        m_axil_wvalid  = r_m_wvalid;
        m_axil_bready  = (r_wstate == WBWAIT);
        m_axil_awaddr  = r_m_awaddr;
        m_axil_awprot  = r_m_awprot;
        m_axil_wdata   = r_m_wdata;
        m_axil_wstrb   = r_m_wstrb;
        s_axil_arready = w_ar_hs;
        s_axil_rvalid  = (r_rstate == RRSP);
        s_axil_rdata   = r_rdata;
        s_axil_rresp   = r_rresp;
        m_axil_arvalid = (r_rstate == RFWD);
        m_axil_rready  = (r_rstate == RWAIT);
        m_axil_araddr  = r_m_araddr;
        m_axil_arprot  = r_m_arprot;
        LED            = r_led;
    end

    // Forwarded AW and W are raised together but each drops on its own ready.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_m_awvalid <= 1'b0;
            r_m_wvalid  <= 1'b0;
            r_m_awaddr  <= '0;
            r_m_awprot  <= '0;
            r_m_wdata   <= '0;
            r_m_wstrb   <= '0;
            r_bresp     <= RESP_OKAY;
        end else begin
            if (w_aw_hs && w_aw_fwd) begin
                r_m_awvalid <= 1'b1;
                r_m_wvalid  <= 1'b1;
                r_m_awaddr  <= s_axil_awaddr[XVC_AW-1:0];
                r_m_awprot  <= s_axil_awprot;
                r_m_wdata   <= s_axil_wdata;
                r_m_wstrb   <= s_axil_wstrb;
            end else begin
                if (m_axil_awready) r_m_awvalid <= 1'b0;
                if (m_axil_wready)  r_m_wvalid  <= 1'b0;
            end
            if (w_aw_hs)
                r_bresp <= w_aw_loc ? RESP_OKAY : RESP_DECERR;
            else if (r_wstate == WBWAIT && m_axil_bvalid)
                r_bresp <= m_axil_bresp;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_led     <= LED_RST;
            r_scratch <= '0;
        end else if (w_loc_wr) begin
            case (s_axil_awaddr[3:2])
                2'd0: if (s_axil_wstrb[0]) r_led <= s_axil_wdata[7:0];
                2'd1: for (int i = 0; i < STRB_WIDTH; i++)
                          if (s_axil_wstrb[i]) r_scratch[i*8 +: 8] <= s_axil_wdata[i*8 +: 8];
                default: ;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_free_cnt <= '0;
        else              r_free_cnt <= r_free_cnt + 32'd1;
    end

    // Reads sample the registers in the handshake cycle, so a same-cycle write is not yet visible.
    always_comb begin
        w_loc_rdata = '0;
        case (s_axil_araddr[3:2])
            2'd0: w_loc_rdata[7:0] = r_led;
            2'd1: w_loc_rdata      = r_scratch;
            2'd2: w_loc_rdata      = r_free_cnt;
            2'd3: w_loc_rdata      = ID_VAL;
            default: w_loc_rdata   = '0;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
            r_m_araddr <= '0;
            r_m_arprot <= '0;
        end else begin
            if (w_ar_hs && w_ar_fwd) begin
                r_m_araddr <= s_axil_araddr[XVC_AW-1:0];
                r_m_arprot <= s_axil_arprot;
            end
            if (w_ar_hs && !w_ar_fwd) begin
                r_rdata <= w_ar_loc ? w_loc_rdata : '0;
                r_rresp <= w_ar_loc ? RESP_OKAY : RESP_DECERR;
            end else if (r_rstate == RWAIT && m_axil_rvalid) begin
                r_rdata <= m_axil_rdata;
                r_rresp <= m_axil_rresp;
            end
        end
    end
endmodule
